// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: two-entry in-order issue buffer sitting in front of an ALU.
// Entries (operands, select, destination tag) are accepted with a valid/ready
// handshake and presented oldest-first. Every output comes straight from a flop,
// so out_ready never reaches in_ready combinationally.
// Optional feature: define ALU_ISSUE_BUFFER_SELCHK_EN to add the sticky
// illegal_op flag, which records any accepted entry with an unsupported select.
module alu_issue_buffer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_sel,
  input  logic [4:0]   in_rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic [3:0]   out_sel,
  output logic [4:0]   out_rd,
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
  output logic         illegal_op,
`endif
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [1:0]   next_count;
  logic         next_in_ready;
  logic         next_out_valid;

  logic         in_ready_r;
  logic         out_valid_r;
  logic [1:0]   count_r;

  logic [N-1:0] head_a;
  logic [N-1:0] head_b;
  logic [3:0]   head_sel;
  logic [4:0]   head_rd;
  logic [N-1:0] tail_a;
  logic [N-1:0] tail_b;
  logic [3:0]   tail_sel;
  logic [4:0]   tail_rd;

  logic         accept;
  logic         consume;

  assign accept  = in_valid & in_ready_r;
  assign consume = out_valid_r & out_ready;

  // Next occupancy state; flush beats every handshake, and FULL never accepts.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) next_state = ONE;
        ONE: begin
          if (accept && !consume)      next_state = FULL;
          else if (!accept && consume) next_state = EMPTY;
        end
        FULL:    if (consume) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Registered handshake/status values derived from the upcoming state.
  always_comb begin
    next_in_ready  = (next_state != FULL);
    next_out_valid = (next_state != EMPTY);
    case (next_state)
      EMPTY:   next_count = 2'd0;
      ONE:     next_count = 2'd1;
      FULL:    next_count = 2'd2;
      default: next_count = 2'd0;
    endcase
  end

  // State, status flops and the two payload slots; head is always the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_a      <= '0;
      head_b      <= '0;
      head_sel    <= '0;
      head_rd     <= '0;
      tail_a      <= '0;
      tail_b      <= '0;
      tail_sel    <= '0;
      tail_rd     <= '0;
    end else begin
      state       <= next_state;
      count_r     <= next_count;
      in_ready_r  <= next_in_ready;
      out_valid_r <= next_out_valid;
      if (!flush) begin
        case (state)
          EMPTY: begin
            if (accept) begin
              head_a   <= in_a;
              head_b   <= in_b;
              head_sel <= in_sel;
              head_rd  <= in_rd;
            end
          end
          ONE: begin
            if (accept && consume) begin
              head_a   <= in_a;
              head_b   <= in_b;
              head_sel <= in_sel;
              head_rd  <= in_rd;
            end else if (accept) begin
              tail_a   <= in_a;
              tail_b   <= in_b;
              tail_sel <= in_sel;
              tail_rd  <= in_rd;
            end
          end
          FULL: begin
            if (consume) begin
              head_a   <= tail_a;
              head_b   <= tail_b;
              head_sel <= tail_sel;
              head_rd  <= tail_rd;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
  logic illegal_r;
  logic sel_legal;

  assign sel_legal = (in_sel == 4'b0000) || (in_sel == 4'b0001) ||
                     (in_sel == 4'b0010) || (in_sel == 4'b0110);

  // Sticky flag for unsupported selects; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (rst)                      illegal_r <= 1'b0;
    else if (accept && !sel_legal) illegal_r <= 1'b1;
  end

  assign illegal_op = illegal_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign out_a     = head_a;
  assign out_b     = head_b;
  assign out_sel   = head_sel;
  assign out_rd    = head_rd;

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Testbench for alu_issue_buffer: directed steps plus a short random run.
// A queue of expected entries is filled when the bench offers an entry that
// the buffer must take, and its head is compared against the DUT every cycle.
// Define ALU_ISSUE_BUFFER_SELCHK_EN to also cover the illegal_op flag.
module tb_alu_issue_buffer;

  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   sel;
    logic [4:0]   rd;
  } entry_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [3:0]   in_sel;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic [3:0]   out_sel;
  logic [4:0]   out_rd;
  logic [1:0]   count;
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
  logic         illegal_op;
  logic         exp_illegal;
`endif

  entry_t sb[$];
  int     checks;
  int     errors;

  alu_issue_buffer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sel   (out_sel),
    .out_rd    (out_rd),
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
    .illegal_op(illegal_op),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sel_ok(input logic [3:0] s);
    return (s == 4'b0000) || (s == 4'b0001) || (s == 4'b0010) || (s == 4'b0110);
  endfunction

  // Compare every DUT output against the scoreboard's view of the buffer.
  task automatic check_output(input string tag);
    check_val({tag, ".count"}, N'(count), N'(sb.size()));
    check_val({tag, ".in_ready"}, N'(in_ready), N'(sb.size() < 2));
    check_val({tag, ".out_valid"}, N'(out_valid), N'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_val({tag, ".out_a"}, out_a, sb[0].a);
      check_val({tag, ".out_b"}, out_b, sb[0].b);
      check_val({tag, ".out_sel"}, N'(out_sel), N'(sb[0].sel));
      check_val({tag, ".out_rd"}, N'(out_rd), N'(sb[0].rd));
    end
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
    check_val({tag, ".illegal_op"}, N'(illegal_op), N'(exp_illegal));
`endif
  endtask

  // Drive one cycle of inputs (called at a falling edge), update the
  // reference model at the rising edge, then check at the next falling edge.
  task automatic apply_stimulus(input string tag, input logic r, input logic f,
                                input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [3:0] s, input logic [4:0] d, input logic ordy);
    int sz;
    bit acc;
    bit con;
    entry_t e;
    rst = r; flush = f; in_valid = v; in_a = a; in_b = b; in_sel = s; in_rd = d;
    out_ready = ordy;
    @(posedge clk);
    sz  = sb.size();
    acc = v && (sz < 2);
    con = (sz != 0) && ordy;
    e.a = a; e.b = b; e.sel = s; e.rd = d;
    if (r) begin
      sb.delete();
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
      exp_illegal = 1'b0;
`endif
    end else begin
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
      if (acc && !sel_ok(s)) exp_illegal = 1'b1;
`endif
      if (f) begin
        sb.delete();
      end else begin
        if (con) void'(sb.pop_front());
        if (acc) sb.push_back(e);
      end
    end
    @(negedge clk);
    check_output(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0; in_rd = '0;
`ifdef ALU_ISSUE_BUFFER_SELCHK_EN
    exp_illegal = 1'b0;
`endif
    @(negedge clk);

    // Reset state, offering an entry that reset must swallow.
    apply_stimulus("reset0", 1, 0, 1, 32'hdead, 32'hbeef, 4'h3, 5'd9, 1);
    apply_stimulus("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
    check_val("reset.out_a", out_a, '0);
    check_val("reset.out_b", out_b, '0);
    check_val("reset.out_sel", N'(out_sel), '0);
    check_val("reset.out_rd", N'(out_rd), '0);

    // Single write becomes visible the following cycle.
    apply_stimulus("single", 0, 0, 1, 5, 3, 4'b0010, 5'd7, 0);
    check_val("single.out_a_const", out_a, 32'd5);
    check_val("single.out_rd_const", N'(out_rd), 32'd7);
    apply_stimulus("single_drain", 0, 0, 0, 0, 0, 0, 0, 1);

    // Backpressure fill; third offer is ignored while FULL.
    apply_stimulus("fill1", 0, 0, 1, 1, 11, 4'b0000, 5'd1, 0);
    apply_stimulus("fill2", 0, 0, 1, 2, 12, 4'b0001, 5'd2, 0);
    check_val("fill2.in_ready_const", N'(in_ready), 32'd0);
    apply_stimulus("fill3_ignored", 0, 0, 1, 3, 13, 4'b0110, 5'd3, 0);
    check_val("fill3.out_a_held", out_a, 32'd1);
    apply_stimulus("hold", 0, 0, 0, 0, 0, 0, 0, 0);

    // Drain in order.
    apply_stimulus("drain1", 0, 0, 0, 0, 0, 0, 0, 1);
    check_val("drain1.out_a_const", out_a, 32'd2);
    apply_stimulus("drain2", 0, 0, 0, 0, 0, 0, 0, 1);

    // Streaming: one in, one out each cycle keeps count at 1.
    apply_stimulus("stream10", 0, 0, 1, 10, 0, 4'b0010, 5'd10, 1);
    apply_stimulus("stream11", 0, 0, 1, 11, 0, 4'b0010, 5'd11, 1);
    apply_stimulus("stream12", 0, 0, 1, 12, 0, 4'b0010, 5'd12, 1);
    check_val("stream12.out_a_const", out_a, 32'd12);
    apply_stimulus("stream_end", 0, 0, 0, 0, 0, 0, 0, 1);

    // Flush with a simultaneous accept in ONE, then in FULL.
    apply_stimulus("pre_flush_one", 0, 0, 1, 4, 4, 4'b0001, 5'd4, 0);
    apply_stimulus("flush_one", 0, 1, 1, 9, 9, 4'b0001, 5'd9, 1);
    apply_stimulus("fill_a", 0, 0, 1, 6, 6, 4'b0000, 5'd6, 0);
    apply_stimulus("fill_b", 0, 0, 1, 7, 7, 4'b0000, 5'd7, 0);
    apply_stimulus("flush_full", 0, 1, 1, 9, 9, 4'b0000, 5'd9, 1);
    apply_stimulus("after_flush", 0, 0, 1, 20, 21, 4'b0110, 5'd20, 0);
    check_val("after_flush.out_a_const", out_a, 32'd20);
    apply_stimulus("after_flush_drain", 0, 0, 0, 0, 0, 0, 0, 1);

    // Select values pass untouched; 0110 is legal, 1111 flags illegal_op.
    apply_stimulus("sel0110", 0, 0, 1, 30, 31, 4'b0110, 5'd30, 1);
    apply_stimulus("sel1111", 0, 0, 1, 32, 33, 4'b1111, 5'd31, 0);
    apply_stimulus("sel_flush", 0, 1, 0, 0, 0, 0, 0, 0);
    apply_stimulus("sel_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("sel_rst", 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-handshake from FULL leaves nothing behind.
    apply_stimulus("mid_a", 0, 0, 1, 40, 0, 4'b0000, 5'd1, 0);
    apply_stimulus("mid_b", 0, 0, 1, 41, 0, 4'b0000, 5'd2, 0);
    apply_stimulus("mid_rst", 1, 0, 1, 42, 0, 4'b0000, 5'd3, 1);
    apply_stimulus("mid_release", 0, 0, 0, 0, 0, 0, 0, 1);

    // Short random run against the same model.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus("rand", 0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                     $urandom, $urandom, 4'($urandom), 5'($urandom),
                     $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_buffer.md
ALU_ISSUE_BUFFER -- requirements
Module: alu_issue_buffer

Interface
REQ-001 Parameter: N, default 32, operand width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous discard of all buffered entries.
REQ-005 Port: in_valid  input  1  upstream offers an entry.
REQ-006 Port: in_ready  output  1  buffer accepts an entry this cycle.
REQ-007 Port: in_a / in_b  input  N  operands A and B.
REQ-008 Port: in_sel  input  4  ALU operation select.
REQ-009 Port: in_rd  input  5  destination register tag.
REQ-010 Port: out_valid  output  1  head entry presented to the ALU.
REQ-011 Port: out_ready  input  1  downstream consumes the head entry.
REQ-012 Port: out_a / out_b  output  N  head operands.
REQ-013 Port: out_sel  output  4  head select.
REQ-014 Port: out_rd  output  5  head destination tag.
REQ-015 Port: count  output  2  occupancy, 0..2.

Function
REQ-016 Two-entry in-order buffer; states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-017 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-018 in_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 exactly when count != 0; out_* SHALL be the oldest entry, driven from registers.
REQ-020 Latency: entry accepted in cycle t SHALL be visible on out_* in cycle t+1 when buffer was EMPTY.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept-only->FULL; ONE+consume-only->EMPTY; ONE+accept+consume->ONE, new entry becomes head; FULL+consume->ONE, second entry becomes head; otherwise hold.
REQ-022 Head payload SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 in_* SHALL be ignored when in_ready=0, regardless of in_valid.
REQ-024 Payload SHALL pass unmodified; sel values 0000, 0001, 0010, 0110 and all others forwarded as received.
REQ-025 flush=1 SHALL force EMPTY next cycle; a simultaneous accept or consume SHALL be discarded; flush overrides all transitions.
REQ-026 in_ready SHALL be 1 in the cycle after flush.
REQ-027 count SHALL always equal the number of valid entries, never exceed 2 or wrap.

Reset
REQ-028 rst=1 at a rising edge SHALL give: state EMPTY, count=0, out_valid=0, in_ready=1, out_a=out_b=0, out_sel=0, out_rd=0.
REQ-029 rst SHALL take priority over flush, accept and consume; entries in flight are lost.
REQ-030 Reset asserted mid-handshake SHALL leave no partial entry after release.

Configuration
REQ-031 Macro ALU_ISSUE_BUFFER_SELCHK_EN, when defined, SHALL add output port illegal_op (1 bit).
REQ-032 With the macro: illegal_op SHALL set on an accept whose in_sel is not 0000, 0001, 0010 or 0110, and stay set until rst; flush does not clear it; entry still forwarded unchanged.
REQ-033 Without the macro: port illegal_op absent, no checking logic, behaviour otherwise identical.

Verification
REQ-034 Reset then single write: in_valid=1, a=5, b=3, sel=0010, rd=7, out_ready=0 -> next cycle out_valid=1, out_a=5, out_b=3, out_sel=0010, out_rd=7, count=1.
REQ-035 Backpressure fill: out_ready=0, two accepts (a=1, a=2) -> count=2, in_ready=0, third offer a=3 ignored; out_a=1 held stable.
REQ-036 Drain order: from FULL, out_ready=1 two cycles -> out_a=1 then 2, count 2->1->0, in_ready back to 1 after first consume.
REQ-037 Streaming: in_valid=1, out_ready=1 continuously, a=10,11,12 -> out_a 10,11,12 on consecutive cycles, count stays 1.
REQ-038 Flush with simultaneous accept in FULL/ONE: flush=1, in_valid=1, a=9 -> next cycle count=0, out_valid=0, a=9 never appears.
REQ-039 With ALU_ISSUE_BUFFER_SELCHK_EN: accept sel=1111 -> illegal_op=1 next cycle, remains 1 through flush, cleared only by rst; sel=0110 never sets it.
